// File: rtl/memory_stage.sv
// Memory-access stage: drives the data-memory request/ack bus, registers ME results.
// Optional bus-timeout watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] Result_EX,
  input  logic [31:0] WrDat_EX,
  input  logic [4:0]  WriteReg_EX,
  input  logic        RegWrite_EX,
  input  logic        MemToReg_EX,
  input  logic        MemWrite_EX,
  output logic        DmReq,
  output logic        DmWe,
  output logic [31:0] DmAddr,
  output logic [31:0] DmWrDat,
  input  logic [31:0] DmRdDat,
  input  logic        DmAck,
  output logic [31:0] ResultRdDat_ME,
  output logic [4:0]  WriteReg_ME,
  output logic        RegWrite_ME,
  output logic        Stall_ME,
  output logic        MemErr_ME
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memory_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        flushed_q, flushed_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regwr_q, regwr_d;

  logic        mem_op_s;
  logic        timeout_s;
  logic        req_s;
  logic        stall_s;
  logic        discard_s;
  logic        from_hold_s;
  logic [31:0] ack_dat_s;

  assign mem_op_s  = MemToReg_EX | MemWrite_EX;
  assign ack_dat_s = timeout_s ? 32'h0 : DmRdDat;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  // Counter is zero outside WAIT, so it is already clear on every WAIT entry.
  always_comb begin
    cnt_d     = 8'd0;
    mem_err_d = mem_err_q | timeout_s;
    if (state_q == ST_WAIT && !timeout_s) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign timeout_s = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_LIMIT);
  assign MemErr_ME = mem_err_q;
`else
  assign timeout_s = 1'b0;
  assign MemErr_ME = 1'b0;
`endif

  // Bus FSM next state: completion in WAIT goes to HOLD only if the pipeline is still frozen.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    flushed_d   = flushed_q;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    discard_s   = 1'b0;
    from_hold_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flushed_d = 1'b0;
        if (mem_op_s && !flush) begin
          req_s = 1'b1;
          if (DmAck) begin
            if (AnyStall) begin
              state_d = ST_HOLD;
              hold_d  = DmRdDat;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stall_s = 1'b1;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (timeout_s || DmAck) begin
          req_s = !timeout_s;
          if (flush || flushed_q) begin
            discard_s = 1'b1;
            flushed_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (AnyStall) begin
            hold_d  = ack_dat_s;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          if (flush) begin
            flushed_d = 1'b1;
          end else begin
            flushed_d = flushed_q;
          end
        end
      end
      ST_HOLD: begin
        from_hold_s = 1'b1;
        if (flush || !AnyStall) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        flushed_d = 1'b0;
      end
    endcase
  end

  // ME pipeline register: a flush or a discarded flushed access clears it.
  always_comb begin
    result_d = result_q;
    wreg_d   = wreg_q;
    regwr_d  = regwr_q;
    if (flush || discard_s) begin
      result_d = 32'h0;
      wreg_d   = 5'd0;
      regwr_d  = 1'b0;
    end else if (!AnyStall) begin
      if (MemToReg_EX) begin
        result_d = from_hold_s ? hold_q : ack_dat_s;
      end else begin
        result_d = Result_EX;
      end
      wreg_d  = WriteReg_EX;
      regwr_d = RegWrite_EX;
    end else begin
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= 32'h0;
      flushed_q <= 1'b0;
      result_q  <= 32'h0;
      wreg_q    <= 5'd0;
      regwr_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      flushed_q <= flushed_d;
      result_q  <= result_d;
      wreg_q    <= wreg_d;
      regwr_q   <= regwr_d;
    end
  end

  // Gate with reset so an abandoned request drops the moment reset asserts.
  assign DmReq    = req_s & ~reset;
  assign Stall_ME = stall_s & ~reset;
  assign DmWe     = MemWrite_EX;
  assign DmAddr   = {Result_EX[31:2], 2'b00};
  assign DmWrDat  = WrDat_EX;

  assign ResultRdDat_ME = result_q;
  assign WriteReg_ME    = wreg_q;
  assign RegWrite_ME    = regwr_q;

endmodule
